// File: rtl/sr_fifo_ext.sv
// sr_fifo_ext: parametrised first-word-fall-through FIFO with occupancy count,
// almost-full/almost-empty thresholds, synchronous flush and sticky error flags.
module sr_fifo_ext #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned AF_LEVEL   = 6,
    parameter int unsigned AE_LEVEL   = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    push,
    input  logic [DATA_WIDTH-1:0]   push_data,
    input  logic                    pop,
    output logic [DATA_WIDTH-1:0]   pop_data,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic                    underflow,
    input  logic                    err_clr
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wrPtr;
    logic [PTR_W-1:0]      rdPtr;
    logic [CNT_W-1:0]      cntQ;
    logic                  overflowQ;
    logic                  underflowQ;

    logic                  pushOk;
    logic                  popOk;
    logic                  overflowSet;
    logic                  underflowSet;

    // Status decodes depend only on the count register, so they move only after an edge
    always_comb begin
        full         = (cntQ == CNT_W'(DEPTH));
        empty        = (cntQ == '0);
        almost_full  = (cntQ >= CNT_W'(AF_LEVEL));
        almost_empty = (cntQ <= CNT_W'(AE_LEVEL));
        count        = cntQ;
        overflow     = overflowQ;
        underflow    = underflowQ;
    end

    // Head word falls through; an empty FIFO presents zeros rather than stale storage
    always_comb begin
        pop_data = '0;
        if (!empty) begin
            pop_data = mem[rdPtr];
        end
    end

    // Acceptance: a pop frees a slot for a push in the same cycle; clear masks both
    always_comb begin
        pushOk       = 1'b0;
        popOk        = 1'b0;
        overflowSet  = 1'b0;
        underflowSet = 1'b0;
        if (!clear) begin
            popOk        = pop && !empty;
            pushOk       = push && (!full || pop);
            overflowSet  = push && !pushOk;
            underflowSet = pop && !popOk;
        end
    end

    // Storage array is deliberately left unreset
    always_ff @(posedge clk) begin
        if (pushOk) begin
            mem[wrPtr] <= push_data;
        end
    end

    // Pointers and occupancy count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            cntQ  <= '0;
        end else if (clear) begin
            wrPtr <= '0;
            rdPtr <= '0;
            cntQ  <= '0;
        end else begin
            if (pushOk) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (popOk) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            if (pushOk && !popOk) begin
                cntQ <= cntQ + CNT_W'(1);
            end else if (popOk && !pushOk) begin
                cntQ <= cntQ - CNT_W'(1);
            end
        end
    end

    // Sticky error flags; a new error in the same cycle beats err_clr
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflowQ  <= 1'b0;
            underflowQ <= 1'b0;
        end else begin
            if (overflowSet) begin
                overflowQ <= 1'b1;
            end else if (err_clr) begin
                overflowQ <= 1'b0;
            end
            if (underflowSet) begin
                underflowQ <= 1'b1;
            end else if (err_clr) begin
                underflowQ <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sr_fifo_ext.sv
// Self-checking bench for sr_fifo_ext (DEPTH=4, AF=3, AE=1, 8-bit data):
// directed scenarios plus randomized traffic against a queue-based reference.
module tb_sr_fifo_ext;

    localparam int unsigned DW  = 8;
    localparam int unsigned DEP = 4;
    localparam int unsigned AF  = 3;
    localparam int unsigned AE  = 1;

    logic          clk;
    logic          rst_n;
    logic          clear;
    logic          push;
    logic [DW-1:0] push_data;
    logic          pop;
    logic [DW-1:0] pop_data;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [2:0]    count;
    logic          overflow;
    logic          underflow;
    logic          err_clr;

    int nVec;
    int nErr;

    // Reference model state
    logic [DW-1:0] mQ[$];
    logic          mOvf;
    logic          mUnf;

    sr_fifo_ext #(
        .DATA_WIDTH(DW),
        .DEPTH(DEP),
        .AF_LEVEL(AF),
        .AE_LEVEL(AE)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .clear(clear),
        .push(push),
        .push_data(push_data),
        .pop(pop),
        .pop_data(pop_data),
        .full(full),
        .empty(empty),
        .almost_full(almost_full),
        .almost_empty(almost_empty),
        .count(count),
        .overflow(overflow),
        .underflow(underflow),
        .err_clr(err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        mQ.delete();
        mOvf = 1'b0;
        mUnf = 1'b0;
    endtask

    // Drive one cycle of inputs, clock it, update the model; returns #1 after the edge
    task automatic cycle(input logic pu, input logic [DW-1:0] pd, input logic po,
                         input logic cl, input logic ec);
        int  sz;
        bit  popAcc;
        bit  pushAcc;
        bit  setO;
        bit  setU;
        push      = pu;
        push_data = pd;
        pop       = po;
        clear     = cl;
        err_clr   = ec;
        sz      = mQ.size();
        popAcc  = 0;
        pushAcc = 0;
        setO    = 0;
        setU    = 0;
        if (!cl) begin
            popAcc  = po && (sz != 0);
            pushAcc = pu && ((sz != DEP) || po);
            setO    = pu && !pushAcc;
            setU    = po && !popAcc;
        end
        @(posedge clk);
        if (cl) begin
            mQ.delete();
        end else begin
            if (popAcc) void'(mQ.pop_front());
            if (pushAcc) mQ.push_back(pd);
        end
        mOvf = setO ? 1'b1 : (ec ? 1'b0 : mOvf);
        mUnf = setU ? 1'b1 : (ec ? 1'b0 : mUnf);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear = 0; push = 0; pop = 0; err_clr = 0; push_data = '0;
        model_reset();
        #12;
        nVec++; if (count !== 3'd0) begin nErr++; $display("FAIL reset_count got %0d want 0", count); end
        nVec++; if (empty !== 1'b1) begin nErr++; $display("FAIL reset_empty got %b want 1", empty); end
        nVec++; if (full !== 1'b0) begin nErr++; $display("FAIL reset_full got %b want 0", full); end
        nVec++; if (almost_empty !== 1'b1) begin nErr++; $display("FAIL reset_ae got %b want 1", almost_empty); end
        nVec++; if (almost_full !== 1'b0) begin nErr++; $display("FAIL reset_af got %b want 0", almost_full); end
        nVec++; if ({overflow, underflow} !== 2'b00) begin nErr++; $display("FAIL reset_err got %b%b want 00", overflow, underflow); end
        nVec++; if (pop_data !== 8'h00) begin nErr++; $display("FAIL reset_popdata got %h want 00", pop_data); end
        rst_n = 1'b1;
    endtask

    task automatic test_fill();
        cycle(1, 8'hA1, 0, 0, 0);
        nVec++; if (count !== 3'd1) begin nErr++; $display("FAIL fill1_count got %0d want 1", count); end
        nVec++; if (pop_data !== 8'hA1) begin nErr++; $display("FAIL fill1_head got %h want a1", pop_data); end
        nVec++; if (almost_empty !== 1'b1) begin nErr++; $display("FAIL fill1_ae got %b want 1", almost_empty); end
        cycle(1, 8'hA2, 0, 0, 0);
        nVec++; if (count !== 3'd2) begin nErr++; $display("FAIL fill2_count got %0d want 2", count); end
        nVec++; if (almost_empty !== 1'b0) begin nErr++; $display("FAIL fill2_ae got %b want 0", almost_empty); end
        nVec++; if (almost_full !== 1'b0) begin nErr++; $display("FAIL fill2_af got %b want 0", almost_full); end
        cycle(1, 8'hA3, 0, 0, 0);
        nVec++; if (count !== 3'd3) begin nErr++; $display("FAIL fill3_count got %0d want 3", count); end
        nVec++; if (almost_full !== 1'b1) begin nErr++; $display("FAIL fill3_af got %b want 1", almost_full); end
        nVec++; if (pop_data !== 8'hA1) begin nErr++; $display("FAIL fill3_head got %h want a1", pop_data); end
    endtask

    task automatic test_overflow();
        logic [DW-1:0] exp [4];
        exp = '{8'hA1, 8'hA2, 8'hA3, 8'hB4};
        cycle(1, 8'hB4, 0, 0, 0);
        nVec++; if (full !== 1'b1) begin nErr++; $display("FAIL ovf_full got %b want 1", full); end
        cycle(1, 8'hFF, 0, 0, 0);
        nVec++; if (count !== 3'd4) begin nErr++; $display("FAIL ovf_count got %0d want 4", count); end
        nVec++; if (overflow !== 1'b1) begin nErr++; $display("FAIL ovf_flag got %b want 1", overflow); end
        nVec++; if (pop_data !== 8'hA1) begin nErr++; $display("FAIL ovf_head got %h want a1", pop_data); end
        for (int i = 0; i < 4; i++) begin
            nVec++; if (pop_data !== exp[i]) begin nErr++; $display("FAIL ovf_drain%0d got %h want %h", i, pop_data, exp[i]); end
            cycle(0, 8'h00, 1, 0, 0);
        end
        nVec++; if (empty !== 1'b1) begin nErr++; $display("FAIL ovf_empty got %b want 1", empty); end
        cycle(0, 8'h00, 0, 0, 1);
        nVec++; if (overflow !== 1'b0) begin nErr++; $display("FAIL ovf_clr got %b want 0", overflow); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] d;
        for (int i = 0; i < 4; i++) cycle(1, 8'(i + 1), 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            d = 8'hC5 + 8'(i);
            cycle(1, d, 1, 0, 0);
            nVec++; if (count !== 3'd4) begin nErr++; $display("FAIL b2b_count%0d got %0d want 4", i, count); end
            nVec++; if (overflow !== 1'b0) begin nErr++; $display("FAIL b2b_ovf%0d got %b want 0", i, overflow); end
        end
        for (int i = 0; i < 4; i++) begin
            d = 8'hC7 + 8'(i);
            nVec++; if (pop_data !== d) begin nErr++; $display("FAIL b2b_drain%0d got %h want %h", i, pop_data, d); end
            cycle(0, 8'h00, 1, 0, 0);
        end
    endtask

    task automatic test_underflow();
        cycle(1, 8'h11, 1, 0, 0);
        nVec++; if (underflow !== 1'b1) begin nErr++; $display("FAIL unf_flag got %b want 1", underflow); end
        nVec++; if (count !== 3'd1) begin nErr++; $display("FAIL unf_count got %0d want 1", count); end
        nVec++; if (pop_data !== 8'h11) begin nErr++; $display("FAIL unf_head got %h want 11", pop_data); end
        cycle(0, 8'h00, 0, 0, 1);
        nVec++; if (underflow !== 1'b0) begin nErr++; $display("FAIL unf_clr got %b want 0", underflow); end
        cycle(0, 8'h00, 1, 0, 0);
        cycle(0, 8'h00, 1, 0, 1);
        nVec++; if (underflow !== 1'b1) begin nErr++; $display("FAIL unf_setwins got %b want 1", underflow); end
    endtask

    task automatic test_clear();
        for (int i = 0; i < 3; i++) cycle(1, 8'h30 + 8'(i), 0, 0, 0);
        cycle(1, 8'h55, 1, 1, 0);
        nVec++; if (count !== 3'd0) begin nErr++; $display("FAIL clr_count got %0d want 0", count); end
        nVec++; if (empty !== 1'b1) begin nErr++; $display("FAIL clr_empty got %b want 1", empty); end
        nVec++; if (pop_data !== 8'h00) begin nErr++; $display("FAIL clr_head got %h want 00", pop_data); end
        nVec++; if ({overflow, underflow} !== 2'b01) begin nErr++; $display("FAIL clr_flags got %b%b want 01", overflow, underflow); end
    endtask

    task automatic test_async_reset();
        cycle(1, 8'h61, 0, 0, 0);
        cycle(1, 8'h62, 0, 0, 0);
        cycle(1, 8'h63, 0, 0, 0);
        cycle(1, 8'h64, 0, 0, 0);
        cycle(1, 8'h65, 0, 0, 0);
        cycle(0, 8'h00, 1, 0, 0);
        cycle(0, 8'h00, 1, 0, 0);
        nVec++; if (count !== 3'd2) begin nErr++; $display("FAIL arst_pre got %0d want 2", count); end
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        nVec++; if (empty !== 1'b1) begin nErr++; $display("FAIL arst_empty got %b want 1", empty); end
        nVec++; if (count !== 3'd0) begin nErr++; $display("FAIL arst_count got %0d want 0", count); end
        nVec++; if ({overflow, underflow} !== 2'b00) begin nErr++; $display("FAIL arst_flags got %b%b want 00", overflow, underflow); end
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic          pu, po, cl, ec;
        logic [DW-1:0] pd;
        int            sz;
        for (int i = 0; i < 400; i++) begin
            pu = ($urandom_range(0, 99) < 55);
            po = ($urandom_range(0, 99) < 50);
            cl = ($urandom_range(0, 99) < 3);
            ec = ($urandom_range(0, 99) < 8);
            pd = 8'($urandom);
            cycle(pu, pd, po, cl, ec);
            sz = mQ.size();
            nVec++; if (count !== 3'(sz)) begin nErr++; $display("FAIL rnd%0d_count got %0d want %0d", i, count, sz); end
            nVec++; if (empty !== (sz == 0)) begin nErr++; $display("FAIL rnd%0d_empty got %b want %b", i, empty, sz == 0); end
            nVec++; if (full !== (sz == DEP)) begin nErr++; $display("FAIL rnd%0d_full got %b want %b", i, full, sz == DEP); end
            nVec++; if (almost_full !== (sz >= AF)) begin nErr++; $display("FAIL rnd%0d_af got %b want %b", i, almost_full, sz >= AF); end
            nVec++; if (almost_empty !== (sz <= AE)) begin nErr++; $display("FAIL rnd%0d_ae got %b want %b", i, almost_empty, sz <= AE); end
            nVec++; if (overflow !== mOvf) begin nErr++; $display("FAIL rnd%0d_ovf got %b want %b", i, overflow, mOvf); end
            nVec++; if (underflow !== mUnf) begin nErr++; $display("FAIL rnd%0d_unf got %b want %b", i, underflow, mUnf); end
            if (sz == 0) begin
                nVec++; if (pop_data !== 8'h00) begin nErr++; $display("FAIL rnd%0d_head got %h want 00", i, pop_data); end
            end else begin
                nVec++; if (pop_data !== mQ[0]) begin nErr++; $display("FAIL rnd%0d_head got %h want %h", i, pop_data, mQ[0]); end
            end
        end
    endtask

    initial begin
        nVec = 0;
        nErr = 0;
        test_reset();
        test_fill();
        test_overflow();
        test_back_to_back();
        test_underflow();
        test_clear();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
